// File: rtl/instr_fetch.sv
// Fetch stage of the multi-cycle RISC-V core: owns PC and IR, issues one word
// read per fetch request and reports misaligned-PC and bus-timeout faults.
module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_we,
  input  logic [31:0] pc_in,
  input  logic        fault_clr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } fetchState_t;

  fetchState_t stateR;
  fetchState_t stateNext;
  logic [7:0]  counterR;
  logic [7:0]  counterNext;
  logic [31:0] pcNext;
  logic [31:0] oldPcNext;
  logic [31:0] instrNext;
  logic [31:0] memAddrNext;
  logic        memReqNext;
  logic        instrValidNext;
  logic [1:0]  faultCodeNext;
  logic        captureS;
  logic        timeoutS;

  // Data arriving on the timeout cycle still counts as a capture.
  assign captureS = ((stateR == S_REQ) || (stateR == S_WAIT)) && mem_rvalid;
  assign timeoutS = (stateR == S_WAIT) && !mem_rvalid && (counterR == LAST_COUNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= S_IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateR;
    case (stateR)
      S_IDLE: begin
        if (pc_we) begin
          stateNext = S_IDLE;
        end else if (fetch_start) begin
          stateNext = (pc[1:0] != 2'b00) ? S_ERR : S_REQ;
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_REQ: begin
        if (captureS) begin
          stateNext = S_IDLE;
        end else begin
          stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (captureS) begin
          stateNext = S_IDLE;
        end else if (timeoutS) begin
          stateNext = S_ERR;
        end else begin
          stateNext = S_WAIT;
        end
      end
      S_ERR: begin
        if (fault_clr) begin
          stateNext = S_IDLE;
        end else begin
          stateNext = S_ERR;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Next values of the datapath registers and registered outputs
  always_comb begin
    pcNext         = pc;
    oldPcNext      = old_pc;
    instrNext      = instr;
    memAddrNext    = mem_addr;
    memReqNext     = 1'b0;
    instrValidNext = 1'b0;
    faultCodeNext  = fault_code;
    counterNext    = counterR;
    case (stateR)
      S_IDLE: begin
        if (pc_we) begin
          pcNext = pc_in;
        end else if (fetch_start && (pc[1:0] != 2'b00)) begin
          faultCodeNext = 2'b01;
        end else if (fetch_start) begin
          memReqNext  = 1'b1;
          memAddrNext = pc;
          counterNext = 8'd0;
        end else begin
          pcNext = pc;
        end
      end
      S_REQ, S_WAIT: begin
        if (captureS) begin
          instrNext      = mem_rdata;
          oldPcNext      = pc;
          pcNext         = pc + 32'd4;
          instrValidNext = 1'b1;
        end else if (timeoutS) begin
          faultCodeNext = 2'b10;
        end else if (stateR == S_WAIT) begin
          counterNext = counterR + 8'd1;
        end else begin
          counterNext = counterR;
        end
      end
      S_ERR: begin
        if (fault_clr) begin
          faultCodeNext = 2'b00;
        end else begin
          faultCodeNext = fault_code;
        end
      end
      default: begin
        faultCodeNext = 2'b00;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      old_pc      <= RESET_PC;
      instr       <= NOP_INSTR;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0000_0000;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      counterR    <= 8'd0;
    end else begin
      pc          <= pcNext;
      old_pc      <= oldPcNext;
      instr       <= instrNext;
      mem_req     <= memReqNext;
      mem_addr    <= memAddrNext;
      instr_valid <= instrValidNext;
      busy        <= (stateNext != S_IDLE);
      fault       <= (stateNext == S_ERR);
      fault_code  <= faultCodeNext;
      counterR    <= counterNext;
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the multi-cycle RISC-V processor.
- Owns the program counter and the instruction register (IR).
- Issues one word read per fetch request and latches the returned word into the IR. The IR feeds the immediate extender and the decoder.
- Provides old_pc (the address of the instruction in the IR), because the PC has already advanced by 4 once a fetch completes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before a bus error; legal range 1..255.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  controller request to fetch at the current pc; honoured only in IDLE.
- pc_we  in  1  controller PC write enable; honoured only in IDLE.
- pc_in  in  32  next PC value (branch/jump target).
- fault_clr  in  1  leave ERR and return to IDLE.
- mem_req  out  1  read strobe, high for exactly one cycle per fetch.
- mem_addr  out  32  read address; equals pc while mem_req is high.
- mem_rdata  in  32  read data, valid when mem_rvalid is high.
- mem_rvalid  in  1  read data valid.
- instr  out  32  instruction register.
- pc  out  32  current PC.
- old_pc  out  32  PC of the instruction held in instr.
- instr_valid  out  1  one-cycle pulse: instr/old_pc/pc were updated on this edge.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  high while in ERR.
- fault_code  out  2  00 none, 01 misaligned PC, 10 bus timeout; held while in ERR.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc=RESET_PC, old_pc=RESET_PC, instr=NOP_INSTR.
  - mem_req=0, mem_addr=0, instr_valid=0, fault=0, fault_code=00.
  - Timeout counter=0, state=IDLE.
  - Reset asserted mid-fetch abandons the fetch; a late mem_rvalid after release is ignored because the state is IDLE.
- States: IDLE, REQ, WAIT, ERR. All outputs are registered.
- IDLE:
  - If pc_we=1: pc<=pc_in. If fetch_start is also 1 in the same cycle, pc_we has priority and fetch_start is dropped; the controller must re-pulse fetch_start.
  - Else if fetch_start=1 and pc[1:0]!=00: go to ERR with fault_code=01; no memory request is issued.
  - Else if fetch_start=1: go to REQ, mem_req<=1, mem_addr<=pc, counter<=0.
  - mem_rvalid is ignored.
- REQ, one cycle:
  - mem_req is high and deasserts on the next edge.
  - If mem_rvalid=1 in this cycle, capture as described below.
  - Otherwise go to WAIT.
- WAIT:
  - If mem_rvalid=1, capture.
  - Else counter<=counter+1. When counter reaches TIMEOUT_CYCLES-1 without rvalid, go to ERR with fault_code=10.
  - mem_rvalid on the same cycle as the timeout wins: capture, no fault.
- Capture, on a single edge:
  - instr<=mem_rdata, old_pc<=pc, pc<=pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
  - instr_valid<=1 for one cycle; next state IDLE.
- Latency: fetch_start in cycle 0 -> mem_req in cycle 1. With rvalid in cycle 1, instr_valid is high in cycle 2 and busy drops in cycle 2.
- In REQ, WAIT and ERR, fetch_start and pc_we are ignored and pc does not change.
- ERR:
  - instr, pc and old_pc are held; fault=1.
  - fault_clr=1 -> IDLE and fault_code<=00. The controller is expected to load pc via pc_we before the next fetch.
- instr and old_pc change only on a capture, so they stay stable for the whole execute/writeback sequence.

Test Plan:
- Reset, then fetch_start with rvalid in the same cycle as mem_req, rdata=32'h00500093 -> mem_addr=0; instr=32'h00500093, old_pc=0, pc=4; instr_valid high 1 cycle in cycle 2.
- Memory returns rvalid 3 cycles after mem_req, rdata=32'hFE000EE3 -> busy high throughout; mem_req high exactly 1 cycle; capture on the rvalid edge; pc=8, old_pc=4.
- pc_we=1, pc_in=32'h0000_0102, then fetch_start -> fault=1, fault_code=01, no mem_req. Then fault_clr, pc_we with 32'h100, fetch -> mem_addr=32'h100.
- No rvalid after mem_req -> ERR with fault_code=10 after TIMEOUT_CYCLES wait cycles; rvalid exactly on the last wait cycle -> normal capture, no fault.
- Same-cycle fetch_start+pc_we in IDLE -> pc updated, no mem_req. pc_we during WAIT -> ignored.
- rst_n pulsed low during WAIT, then a stale rvalid with 32'hDEADBEEF -> instr stays 32'h00000013, pc=RESET_PC, no instr_valid.
- pc=32'hFFFF_FFFC fetch -> pc wraps to 0, old_pc=32'hFFFF_FFFC.
